// File: rtl/pid_mac_sequencer_if.sv
// Request/result bundle between the sampled-error source, the PID core and the actuator word.
// The master side drives error, gains and control strobes; the slave (core) returns uk/Done/Busy.
interface pid_mac_sequencer_if #(
    parameter int W = 19
);
    logic                Start;
    logic signed [W-1:0] ek;
    logic signed [W-1:0] Kp;
    logic signed [W-1:0] Ki;
    logic signed [W-1:0] Kd;
    logic                Hold;
    logic                Clear;
    logic signed [W-1:0] uk;
    logic                Done;
    logic                Busy;

    modport master (output Start, ek, Kp, Ki, Kd, Hold, Clear, input uk, Done, Busy);
    modport slave  (input Start, ek, Kp, Ki, Kd, Hold, Clear, output uk, Done, Busy);
endinterface

// File: rtl/pid_mac_sequencer.sv
// Discrete PID core: one shared multiplier sequenced over the P, I and D terms,
// saturating integrator, and a registered, saturated controller output.
module pid_mac_sequencer #(
    parameter int W    = 19,
    parameter int FRAC = 0
) (
    input  logic               CLK,
    input  logic               Reset,
    pid_mac_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SUM, DONE} state_t;

    localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    state_t              state_q, state_d;
    logic signed [W-1:0] ek_q, ek_d;
    logic signed [W-1:0] kp_q, kp_d;
    logic signed [W-1:0] ki_q, ki_d;
    logic signed [W-1:0] kd_q, kd_d;
    logic signed [W-1:0] p_q, p_d;
    logic signed [W-1:0] d_q, d_d;
    logic signed [W-1:0] i_acc_q, i_acc_d;
    logic signed [W-1:0] e_prev_q, e_prev_d;
    logic signed [W-1:0] uk_q, uk_d;

    logic signed [W-1:0]   mul_a, mul_b, diff_sat, prod_sat;
    logic signed [2*W-1:0] prod, prod_shift;
    logic signed [W+1:0]   sum_w2;

    // Every intermediate is widened to 2W+1 bits so no comparison or addition can wrap.
    function automatic logic signed [2*W:0] ext(input logic signed [W-1:0] v);
        return {{(W+1){v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return x[W-1:0];
    endfunction

    assign diff_sat = sat(ext(ek_q) - ext(e_prev_q));

    always_comb begin
        mul_a = kp_q;
        mul_b = ek_q;
        case (state_q)
            MUL_I:   mul_a = ki_q;
            MUL_D: begin
                mul_a = kd_q;
                mul_b = diff_sat;
            end
            default: ;
        endcase
    end

    assign prod       = mul_a * mul_b;
    assign prod_shift = prod >>> FRAC;
    assign prod_sat   = sat({prod_shift[2*W-1], prod_shift});
    assign sum_w2     = {{2{p_q[W-1]}}, p_q} + {{2{i_acc_q[W-1]}}, i_acc_q} + {{2{d_q[W-1]}}, d_q};

    always_comb begin
        state_d  = state_q;
        ek_d     = ek_q;
        kp_d     = kp_q;
        ki_d     = ki_q;
        kd_d     = kd_q;
        p_d      = p_q;
        d_d      = d_q;
        i_acc_d  = i_acc_q;
        e_prev_d = e_prev_q;
        uk_d     = uk_q;
        case (state_q)
            IDLE: begin
                // Clear lands before the first multiply, so a simultaneous Start sees zeroed history.
                if (bus.Clear) begin
                    i_acc_d  = '0;
                    e_prev_d = '0;
                end
                if (bus.Start) begin
                    ek_d    = bus.ek;
                    kp_d    = bus.Kp;
                    ki_d    = bus.Ki;
                    kd_d    = bus.Kd;
                    state_d = MUL_P;
                end
            end
            MUL_P: begin
                p_d     = prod_sat;
                state_d = MUL_I;
            end
            MUL_I: begin
                if (!bus.Hold) begin
                    i_acc_d = sat(ext(i_acc_q) + ext(prod_sat));
                end
                state_d = MUL_D;
            end
            MUL_D: begin
                d_d     = prod_sat;
                state_d = SUM;
            end
            SUM: begin
                uk_d     = sat({{(W-1){sum_w2[W+1]}}, sum_w2});
                e_prev_d = ek_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= IDLE;
            ek_q     <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            p_q      <= '0;
            d_q      <= '0;
            i_acc_q  <= '0;
            e_prev_q <= '0;
            uk_q     <= '0;
        end else begin
            state_q  <= state_d;
            ek_q     <= ek_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            kd_q     <= kd_d;
            p_q      <= p_d;
            d_q      <= d_d;
            i_acc_q  <= i_acc_d;
            e_prev_q <= e_prev_d;
            uk_q     <= uk_d;
        end
    end

    assign bus.uk   = uk_q;
    assign bus.Done = (state_q == DONE);
    assign bus.Busy = (state_q != IDLE);
endmodule

// File: tb/tb_pid_mac_sequencer.sv
// Drives identical samples into a FRAC=0 and a FRAC=8 core and scores both against
// a behavioural PID model whose expected outputs are queued at Start and popped at Done.
module tb_pid_mac_sequencer;
    localparam int     W    = 19;
    localparam longint MAXV = 262143;
    localparam longint MINV = -262144;

    logic                clk;
    logic                reset_n;
    logic                start, hold, clear;
    logic signed [W-1:0] ek, kp, ki, kd;

    int total = 0;
    int bad   = 0;

    longint m_iacc[2];
    longint m_eprev[2];
    int     m_frac[2];
    longint q0[$];
    longint q1[$];

    pid_mac_sequencer_if #(.W(W)) bus0 ();
    pid_mac_sequencer_if #(.W(W)) bus1 ();

    assign bus0.Start = start;
    assign bus0.ek    = ek;
    assign bus0.Kp    = kp;
    assign bus0.Ki    = ki;
    assign bus0.Kd    = kd;
    assign bus0.Hold  = hold;
    assign bus0.Clear = clear;
    assign bus1.Start = start;
    assign bus1.ek    = ek;
    assign bus1.Kp    = kp;
    assign bus1.Ki    = ki;
    assign bus1.Kd    = kd;
    assign bus1.Hold  = hold;
    assign bus1.Clear = clear;

    pid_mac_sequencer #(.W(W), .FRAC(0)) dut0 (.CLK(clk), .Reset(reset_n), .bus(bus0));
    pid_mac_sequencer #(.W(W), .FRAC(8)) dut1 (.CLK(clk), .Reset(reset_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint satw(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint model_step(input int n, input longint e, input longint p,
                                          input longint i, input longint d, input bit h);
        longint pr, df, dr;
        pr = satw((p * e) >>> m_frac[n]);
        if (!h) m_iacc[n] = satw(m_iacc[n] + satw((i * e) >>> m_frac[n]));
        df = satw(e - m_eprev[n]);
        dr = satw((d * df) >>> m_frac[n]);
        m_eprev[n] = e;
        return satw(pr + m_iacc[n] + dr);
    endfunction

    task automatic check_output(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_iacc[n]  = 0;
            m_eprev[n] = 0;
        end
    endtask

    // Caller is at a negedge; Start is sampled at the next posedge.
    task automatic apply_stimulus(input longint e, input longint p, input longint i, input longint d,
                                  input bit h, input bit c, input bit glitch);
        int k;
        int busy_cycles;
        longint exp0, exp1;
        ek    = W'(e);
        kp    = W'(p);
        ki    = W'(i);
        kd    = W'(d);
        hold  = h;
        clear = c;
        start = 1'b1;
        if (c) model_reset();
        q0.push_back(model_step(0, e, p, i, d, h));
        q1.push_back(model_step(1, e, p, i, d, h));
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        k = 0;
        busy_cycles = 0;
        while (!bus0.Done && k < 12) begin
            if (bus0.Busy) busy_cycles++;
            start = (glitch && k == 1);
            ek = W'($urandom);
            kp = W'($urandom);
            ki = W'($urandom);
            kd = W'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (bus0.Busy) busy_cycles++;
        check_output("done_latency", k, 4);
        check_output("busy_cycles", busy_cycles, 5);
        check_output("done_sync", bus1.Done, 1);
        exp0 = (q0.size() > 0) ? q0.pop_front() : 0;
        exp1 = (q1.size() > 0) ? q1.pop_front() : 0;
        check_output("uk_frac0", bus0.uk, exp0);
        check_output("uk_frac8", bus1.uk, exp1);
        hold = 1'b0;
        @(negedge clk);
        check_output("done_one_cycle", bus0.Done, 0);
        check_output("busy_idle", bus0.Busy, 0);
        check_output("uk_hold", bus0.uk, exp0);
    endtask

    task automatic check_no_done(input int cycles);
        int dones = 0;
        for (int c = 0; c < cycles; c++) begin
            if (bus0.Done || bus1.Done) dones++;
            @(negedge clk);
        end
        check_output("no_extra_done", dones, 0);
    endtask

    initial begin
        m_frac[0] = 0;
        m_frac[1] = 8;
        model_reset();
        reset_n = 1'b0;
        start = 1'b0; hold = 1'b0; clear = 1'b0;
        ek = '0; kp = '0; ki = '0; kd = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_output("reset_uk", bus0.uk, 0);
        check_output("reset_busy", bus0.Busy, 0);
        check_output("reset_done", bus0.Done, 0);
        check_output("reset_uk_frac8", bus1.uk, 0);
        $display("[TB] basic PID and back-to-back samples");
        apply_stimulus(10, 2, 7, 1, 0, 0, 0);
        apply_stimulus(10, 2, 7, 1, 0, 0, 0);
        apply_stimulus(4, 2, 7, 1, 0, 0, 0);
        $display("[TB] integrator saturation");
        apply_stimulus(100000, 0, 7, 0, 0, 1, 0);
        apply_stimulus(100000, 0, 7, 0, 0, 0, 0);
        apply_stimulus(-100000, 0, 7, 0, 0, 0, 0);
        $display("[TB] clear in idle then hold");
        clear = 1'b1;
        model_reset();
        @(negedge clk);
        clear = 1'b0;
        apply_stimulus(10, 2, 7, 1, 1, 0, 0);
        apply_stimulus(10, 2, 7, 1, 1, 0, 0);
        $display("[TB] start while busy is ignored");
        apply_stimulus(5, 2, 7, 1, 0, 0, 1);
        check_no_done(8);
        $display("[TB] reset mid-sequence");
        ek = 19'sd50; kp = 19'sd3; ki = 19'sd3; kd = 19'sd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_output("midreset_uk", bus0.uk, 0);
        check_output("midreset_busy", bus0.Busy, 0);
        check_output("midreset_done", bus0.Done, 0);
        check_no_done(8);
        $display("[TB] fractional gains and product saturation");
        apply_stimulus(-200, 384, 0, 0, 0, 0, 0);
        apply_stimulus(-262144, -262144, 0, 0, 0, 0, 0);
        $display("[TB] random samples");
        for (int r = 0; r < 4; r++) begin
            apply_stimulus(longint'($urandom_range(0, 4000)) - 2000,
                           longint'($urandom_range(0, 1000)) - 500,
                           longint'($urandom_range(0, 1000)) - 500,
                           longint'($urandom_range(0, 1000)) - 500,
                           bit'($urandom_range(0, 1)), 0, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
